fft32_stage2: RTL and testbench

- Third radix-2 decimation-in-frequency (DIF) stage of a fully parallel 32-point FFT datapath. Stages are numbered from 0.
- Takes 32 complex samples per clock and splits them into four independent 8-point groups.
- In each group it runs 4 butterflies with span 4. The difference leg of each butterfly is multiplied by twiddle W8^k.
- All 32 results are registered. Throughput is one full vector per clock.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_bfly_dif.sv | 48 ++++
 rtl/fft32_stage2.sv | 79 +++++++
 tb/tb_fft32_stage2.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types, twiddle constants and reduction helper for the parallel 32-point FFT stages.
package fft_pkg;

  localparam int unsigned REAL_BITS = 10;
  localparam int unsigned TW_BITS   = 8;
  localparam int unsigned TW_FRAC   = 3;
  localparam int unsigned FULL_BITS = 2 * REAL_BITS;

  typedef struct packed {
    logic signed [REAL_BITS-1:0] re;
    logic signed [REAL_BITS-1:0] im;
  } complex_t;

  // W8^k, 8-bit components with TW_FRAC fractional bits (1.0 = 8)
  localparam logic [2*TW_BITS-1:0] W8_0 = 16'h0800;
  localparam logic [2*TW_BITS-1:0] W8_1 = 16'h05FB;
  localparam logic [2*TW_BITS-1:0] W8_2 = 16'h00F8;
  localparam logic [2*TW_BITS-1:0] W8_3 = 16'hFBFB;

  function automatic logic signed [REAL_BITS-1:0] sat10(input logic signed [FULL_BITS-1:0] x);
    if (x > 20'sd511) begin
      return 10'h1FF;
    end else if (x < -20'sd512) begin
      return 10'h200;
    end else begin
      return x[REAL_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/fft_bfly_dif.sv
// Radix-2 DIF butterfly: sum leg plus twiddle-rotated difference leg scaled by 2^-SHIFT.
// FFT32_STAGE2_SAT_EN selects clamping instead of two's-complement wrap on each output component.
module fft_bfly_dif
  import fft_pkg::*;
#(
  parameter int unsigned SHIFT = TW_FRAC
) (
  input  complex_t             a_i,
  input  complex_t             b_i,
  input  logic [2*TW_BITS-1:0] w_i,
  output complex_t             sum_o,
  output complex_t             diff_o
);

  logic signed [REAL_BITS:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [TW_BITS-1:0]   w_re, w_im;
  logic signed [FULL_BITS-1:0] prod_re, prod_im;
  logic signed [FULL_BITS-1:0] full_re_s, full_im_s, full_re_d, full_im_d;

  always_comb begin
    sum_re = {a_i.re[REAL_BITS-1], a_i.re} + {b_i.re[REAL_BITS-1], b_i.re};
    sum_im = {a_i.im[REAL_BITS-1], a_i.im} + {b_i.im[REAL_BITS-1], b_i.im};
    dif_re = {a_i.re[REAL_BITS-1], a_i.re} - {b_i.re[REAL_BITS-1], b_i.re};
    dif_im = {a_i.im[REAL_BITS-1], a_i.im} - {b_i.im[REAL_BITS-1], b_i.im};
    w_re   = w_i[2*TW_BITS-1:TW_BITS];
    w_im   = w_i[TW_BITS-1:0];
    // 11x8 products summed cannot exceed 20 bits, so the 20-bit wrap is exact
    prod_re = FULL_BITS'(dif_re) * FULL_BITS'(w_re) - FULL_BITS'(dif_im) * FULL_BITS'(w_im);
    prod_im = FULL_BITS'(dif_re) * FULL_BITS'(w_im) + FULL_BITS'(dif_im) * FULL_BITS'(w_re);
    full_re_s = FULL_BITS'(sum_re);
    full_im_s = FULL_BITS'(sum_im);
    full_re_d = prod_re >>> SHIFT;
    full_im_d = prod_im >>> SHIFT;
  end

`ifdef FFT32_STAGE2_SAT_EN
  assign sum_o  = {sat10(full_re_s), sat10(full_im_s)};
  assign diff_o = {sat10(full_re_d), sat10(full_im_d)};
`else
  logic unused_hi;

  assign sum_o  = {full_re_s[REAL_BITS-1:0], full_im_s[REAL_BITS-1:0]};
  assign diff_o = {full_re_d[REAL_BITS-1:0], full_im_d[REAL_BITS-1:0]};
  assign unused_hi = ^{full_re_s[FULL_BITS-1:REAL_BITS], full_im_s[FULL_BITS-1:REAL_BITS],
                       full_re_d[FULL_BITS-1:REAL_BITS], full_im_d[FULL_BITS-1:REAL_BITS]};
`endif

endmodule

// File: rtl/fft32_stage2.sv
// Stage 2 of the parallel 32-point DIF FFT: four 8-point groups, span-4 butterflies, registered outputs.
// Optional FFT32_STAGE2_SAT_EN clamps output components instead of wrapping them.
module fft32_stage2
  import fft_pkg::*;
#(
  parameter int p_inputBits             = 20,
  parameter int p_outputBits            = 20,
  parameter int p_widdleBits            = 16,
  parameter int p_PointPosition         = 3,
  parameter int p_realBits              = 10,
  parameter int p_numberOf_unneded_bits = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [p_inputBits-1:0]  i_b0,  i_b1,  i_b2,  i_b3,  i_b4,  i_b5,  i_b6,  i_b7,
  input  logic [p_inputBits-1:0]  i_b8,  i_b9,  i_b10, i_b11, i_b12, i_b13, i_b14, i_b15,
  input  logic [p_inputBits-1:0]  i_b16, i_b17, i_b18, i_b19, i_b20, i_b21, i_b22, i_b23,
  input  logic [p_inputBits-1:0]  i_b24, i_b25, i_b26, i_b27, i_b28, i_b29, i_b30, i_b31,
  input  logic [p_widdleBits-1:0] i_w08, i_w18, i_w28, i_w38,
  output logic [p_outputBits-1:0] o_c0,  o_c1,  o_c2,  o_c3,  o_c4,  o_c5,  o_c6,  o_c7,
  output logic [p_outputBits-1:0] o_c8,  o_c9,  o_c10, o_c11, o_c12, o_c13, o_c14, o_c15,
  output logic [p_outputBits-1:0] o_c16, o_c17, o_c18, o_c19, o_c20, o_c21, o_c22, o_c23,
  output logic [p_outputBits-1:0] o_c24, o_c25, o_c26, o_c27, o_c28, o_c29, o_c30, o_c31
);

  // Component layout is fixed by complex_t; these remain only for neighbour-stage compatibility
  localparam int unused_cfg = p_numberOf_unneded_bits + p_realBits;

  complex_t                b_w [32];
  complex_t                c_d [32];
  complex_t                c_q [32];
  logic [p_widdleBits-1:0] w_w [4];

  assign b_w[0]  = i_b0;  assign b_w[1]  = i_b1;  assign b_w[2]  = i_b2;  assign b_w[3]  = i_b3;
  assign b_w[4]  = i_b4;  assign b_w[5]  = i_b5;  assign b_w[6]  = i_b6;  assign b_w[7]  = i_b7;
  assign b_w[8]  = i_b8;  assign b_w[9]  = i_b9;  assign b_w[10] = i_b10; assign b_w[11] = i_b11;
  assign b_w[12] = i_b12; assign b_w[13] = i_b13; assign b_w[14] = i_b14; assign b_w[15] = i_b15;
  assign b_w[16] = i_b16; assign b_w[17] = i_b17; assign b_w[18] = i_b18; assign b_w[19] = i_b19;
  assign b_w[20] = i_b20; assign b_w[21] = i_b21; assign b_w[22] = i_b22; assign b_w[23] = i_b23;
  assign b_w[24] = i_b24; assign b_w[25] = i_b25; assign b_w[26] = i_b26; assign b_w[27] = i_b27;
  assign b_w[28] = i_b28; assign b_w[29] = i_b29; assign b_w[30] = i_b30; assign b_w[31] = i_b31;

  assign w_w[0] = i_w08;
  assign w_w[1] = i_w18;
  assign w_w[2] = i_w28;
  assign w_w[3] = i_w38;

  for (genvar g = 0; g < 4; g++) begin : g_group
    for (genvar k = 0; k < 4; k++) begin : g_bfly
      fft_bfly_dif #(
        .SHIFT(p_PointPosition)
      ) u_bfly (
        .a_i   (b_w[8*g+k]),
        .b_i   (b_w[8*g+k+4]),
        .w_i   (w_w[k]),
        .sum_o (c_d[8*g+k]),
        .diff_o(c_d[8*g+k+4])
      );
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 32; i++) c_q[i] <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign o_c0  = c_q[0];  assign o_c1  = c_q[1];  assign o_c2  = c_q[2];  assign o_c3  = c_q[3];
  assign o_c4  = c_q[4];  assign o_c5  = c_q[5];  assign o_c6  = c_q[6];  assign o_c7  = c_q[7];
  assign o_c8  = c_q[8];  assign o_c9  = c_q[9];  assign o_c10 = c_q[10]; assign o_c11 = c_q[11];
  assign o_c12 = c_q[12]; assign o_c13 = c_q[13]; assign o_c14 = c_q[14]; assign o_c15 = c_q[15];
  assign o_c16 = c_q[16]; assign o_c17 = c_q[17]; assign o_c18 = c_q[18]; assign o_c19 = c_q[19];
  assign o_c20 = c_q[20]; assign o_c21 = c_q[21]; assign o_c22 = c_q[22]; assign o_c23 = c_q[23];
  assign o_c24 = c_q[24]; assign o_c25 = c_q[25]; assign o_c26 = c_q[26]; assign o_c27 = c_q[27];
  assign o_c28 = c_q[28]; assign o_c29 = c_q[29]; assign o_c30 = c_q[30]; assign o_c31 = c_q[31];

endmodule

// File: tb/tb_fft32_stage2.sv
// Directed and model-based bench for fft32_stage2; honours FFT32_STAGE2_SAT_EN when defined.
module tb_fft32_stage2;
  import fft_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [19:0] ib    [32];
  logic [15:0] iw    [4];
  logic [19:0] oc    [32];
  logic [19:0] exp_c [32];
  int          checks = 0;
  int          errors = 0;

`ifdef FFT32_STAGE2_SAT_EN
  localparam logic [19:0] SAT_POS = 20'h7FDFF;
  localparam logic [19:0] SAT_NEG = 20'h80200;
`else
  localparam logic [19:0] SAT_POS = 20'hFFBFE;
  localparam logic [19:0] SAT_NEG = 20'h00000;
`endif

  always #5 CLK = ~CLK;

  fft32_stage2 #(
    .p_inputBits(20), .p_outputBits(20), .p_widdleBits(16),
    .p_PointPosition(3), .p_realBits(10), .p_numberOf_unneded_bits(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_b0(ib[0]),   .i_b1(ib[1]),   .i_b2(ib[2]),   .i_b3(ib[3]),
    .i_b4(ib[4]),   .i_b5(ib[5]),   .i_b6(ib[6]),   .i_b7(ib[7]),
    .i_b8(ib[8]),   .i_b9(ib[9]),   .i_b10(ib[10]), .i_b11(ib[11]),
    .i_b12(ib[12]), .i_b13(ib[13]), .i_b14(ib[14]), .i_b15(ib[15]),
    .i_b16(ib[16]), .i_b17(ib[17]), .i_b18(ib[18]), .i_b19(ib[19]),
    .i_b20(ib[20]), .i_b21(ib[21]), .i_b22(ib[22]), .i_b23(ib[23]),
    .i_b24(ib[24]), .i_b25(ib[25]), .i_b26(ib[26]), .i_b27(ib[27]),
    .i_b28(ib[28]), .i_b29(ib[29]), .i_b30(ib[30]), .i_b31(ib[31]),
    .i_w08(iw[0]), .i_w18(iw[1]), .i_w28(iw[2]), .i_w38(iw[3]),
    .o_c0(oc[0]),   .o_c1(oc[1]),   .o_c2(oc[2]),   .o_c3(oc[3]),
    .o_c4(oc[4]),   .o_c5(oc[5]),   .o_c6(oc[6]),   .o_c7(oc[7]),
    .o_c8(oc[8]),   .o_c9(oc[9]),   .o_c10(oc[10]), .o_c11(oc[11]),
    .o_c12(oc[12]), .o_c13(oc[13]), .o_c14(oc[14]), .o_c15(oc[15]),
    .o_c16(oc[16]), .o_c17(oc[17]), .o_c18(oc[18]), .o_c19(oc[19]),
    .o_c20(oc[20]), .o_c21(oc[21]), .o_c22(oc[22]), .o_c23(oc[23]),
    .o_c24(oc[24]), .o_c25(oc[25]), .o_c26(oc[26]), .o_c27(oc[27]),
    .o_c28(oc[28]), .o_c29(oc[29]), .o_c30(oc[30]), .o_c31(oc[31])
  );

  function automatic int red(input int x);
`ifdef FFT32_STAGE2_SAT_EN
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
`else
    int m;
    m = x & 1023;
    return (m >= 512) ? m - 1024 : m;
`endif
  endfunction

  function automatic logic [19:0] pack(input int re, input int im);
    logic [9:0] r;
    logic [9:0] i;
    r = 10'(red(re));
    i = 10'(red(im));
    return {r, i};
  endfunction

  task automatic model();
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        int n, ar, ai, br, bi, dr, di, wr, wi;
        n  = 8 * g + k;
        ar = int'($signed(ib[n][19:10]));
        ai = int'($signed(ib[n][9:0]));
        br = int'($signed(ib[n+4][19:10]));
        bi = int'($signed(ib[n+4][9:0]));
        wr = int'($signed(iw[k][15:8]));
        wi = int'($signed(iw[k][7:0]));
        dr = ar - br;
        di = ai - bi;
        exp_c[n]   = pack(ar + br, ai + bi);
        exp_c[n+4] = pack((dr * wr - di * wi) >>> 3, (dr * wi + di * wr) >>> 3);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    for (int i = 0; i < 32; i++) ib[i] = '0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) exp_c[i] = '0;
  endtask

  task automatic rand_in();
    for (int i = 0; i < 32; i++) ib[i] = 20'($urandom);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      checks++;
      assert (oc[i] === exp_c[i]) else begin
        errors++;
        $error("FAIL %s c%0d got %h expected %h", tag, i, oc[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rand_in();
      for (int k = 0; k < 4; k++) iw[k] = 16'($urandom);
      tick();
      clear_exp();
      check_all("reset");
    end

    RST = 1'b0;
    clear_in();
    for (int k = 0; k < 4; k++) iw[k] = W8_0;
    ib[0] = 20'h00400;
    tick();
    clear_exp();
    exp_c[0] = 20'h00400; exp_c[4] = 20'h00400;
    check_all("unity");

    iw[0] = W8_0; iw[1] = W8_1; iw[2] = W8_2; iw[3] = W8_3;
    clear_in();
    ib[1] = 20'h02000;
    tick();
    clear_exp();
    exp_c[1] = 20'h02000; exp_c[5] = 20'h017FB;
    check_all("w8_1");

    clear_in();
    ib[2] = 20'h00C01;
    tick();
    clear_exp();
    exp_c[2] = 20'h00C01; exp_c[6] = 20'h007FD;
    check_all("w8_2");

    clear_in();
    ib[3]  = 20'h02000;
    ib[9]  = 20'h00400;
    ib[11] = 20'h00400;
    ib[16] = 20'h00400; ib[20] = 20'h00C00;
    tick();
    clear_exp();
    exp_c[3]  = 20'h02000; exp_c[7]  = 20'hFEFFB;
    exp_c[9]  = 20'h00400; exp_c[13] = 20'h003FF;
    exp_c[11] = 20'h00400; exp_c[15] = 20'hFFFFF;
    exp_c[16] = 20'h01000; exp_c[20] = 20'hFF800;
    check_all("floor_groups");

    for (int i = 0; i < 32; i++) ib[i] = 20'h7FDFF;
    tick();
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++) begin
        exp_c[8*g+k] = SAT_POS; exp_c[8*g+k+4] = '0;
      end
    check_all("sat_pos");

    for (int i = 0; i < 32; i++) ib[i] = 20'h80200;
    tick();
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++) begin
        exp_c[8*g+k] = SAT_NEG; exp_c[8*g+k+4] = '0;
      end
    check_all("sat_neg");

    for (int t = 0; t < 1000; t++) begin
      if (t == 500) begin
        RST = 1'b1;
        rand_in();
        tick();
        clear_exp();
        check_all("mid_reset");
        RST = 1'b0;
      end
      rand_in();
      model();
      tick();
      check_all("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
